// File: rtl/sys_array_feeder_if.sv
// Vector stream into the systolic-array feeder: one ROWS-lane sample
// vector per transfer over a valid/ready handshake.
interface sys_array_feeder_if #(
    parameter int ROWS       = 4,
    parameter int DATA_WIDTH = 8
);
    logic                         vec_valid;
    logic [ROWS*DATA_WIDTH-1:0]   vec_data;
    logic                         vec_ready;

    modport master (output vec_valid, output vec_data, input vec_ready);
    modport slave  (input vec_valid, input vec_data, output vec_ready);
endinterface

// File: rtl/sys_array_feeder.sv
// Systolic-array feeder: latches a weight set, pulses param_load, then streams
// input vectors onto the array's left edge with per-lane diagonal skew and a zero drain.
module sys_array_feeder #(
    parameter int DATA_WIDTH  = 8,
    parameter int ROWS        = 4,
    parameter int COLS        = 4,
    parameter int MAX_VECTORS = 16,
    parameter int CNT_W       = $clog2(MAX_VECTORS + 1)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            start,
    input  logic [CNT_W-1:0]                num_vectors,
    input  logic [ROWS*COLS*DATA_WIDTH-1:0] param_in,
    sys_array_feeder_if.slave               vec_if,
    output logic                            param_load,
    output logic [ROWS*COLS*DATA_WIDTH-1:0] param_data,
    output logic [ROWS*DATA_WIDTH-1:0]      array_data,
    output logic [ROWS-1:0]                 array_valid,
    output logic                            busy,
    output logic                            done
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] LOAD  = 2'd1;
    localparam logic [1:0] FEED  = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    localparam int DRAIN_LEN = ROWS + COLS - 1;
    localparam int DRN_W     = $clog2(ROWS + COLS);

    logic [1:0]       state;
    logic [CNT_W-1:0] n_reg;
    logic [CNT_W-1:0] acc_cnt;
    logic [CNT_W-1:0] n_clamped;
    logic [DRN_W-1:0] drain_cnt;
    logic             fire;
    logic             shift_en;

    always_comb begin
        n_clamped = num_vectors;
        if (num_vectors > CNT_W'(MAX_VECTORS))
            n_clamped = CNT_W'(MAX_VECTORS);
    end

    assign vec_if.vec_ready = (state == FEED) && (acc_cnt < n_reg);
    assign fire             = vec_if.vec_valid && vec_if.vec_ready;
    assign shift_en         = (state == FEED) || (state == DRAIN);
    assign param_load       = (state == LOAD);
    assign busy             = (state != IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            n_reg      <= '0;
            acc_cnt    <= '0;
            drain_cnt  <= '0;
            param_data <= '0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (num_vectors == '0) begin
                            done <= 1'b1;
                        end else begin
                            n_reg      <= n_clamped;
                            param_data <= param_in;
                            acc_cnt    <= '0;
                            state      <= LOAD;
                        end
                    end
                end
                LOAD: state <= FEED;
                FEED: begin
                    if (fire) begin
                        acc_cnt <= acc_cnt + CNT_W'(1);
                        if (acc_cnt + CNT_W'(1) == n_reg) begin
                            drain_cnt <= '0;
                            state     <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (drain_cnt == DRN_W'(DRAIN_LEN - 1)) begin
                        done  <= 1'b1;
                        state <= IDLE;
                    end else begin
                        drain_cnt <= drain_cnt + DRN_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Lane r is an (r+1)-deep shift chain; idle/load cycles flush it to zero.
    for (genvar r = 0; r < ROWS; r++) begin : g_lane
        logic [DATA_WIDTH-1:0] sd [0:r];
        logic [r:0]            sv;

        always_ff @(posedge clk) begin
            if (reset || !shift_en) begin
                for (int unsigned k = 0; k <= r; k++)
                    sd[k] <= '0;
                sv <= '0;
            end else begin
                sd[0] <= fire ? vec_if.vec_data[r*DATA_WIDTH +: DATA_WIDTH] : '0;
                sv[0] <= fire;
                for (int unsigned k = 1; k <= r; k++) begin
                    sd[k] <= sd[k-1];
                    sv[k] <= sv[k-1];
                end
            end
        end

        assign array_data[r*DATA_WIDTH +: DATA_WIDTH] = sd[r];
        assign array_valid[r]                         = sv[r];
    end
endmodule

// File: tb/tb_sys_array_feeder.sv
// Scoreboard bench for sys_array_feeder: expected lane samples are queued at
// transfer time and retired when the matching lane shows a valid sample.
module tb_sys_array_feeder;
    localparam int DW = 8;
    localparam int R  = 4;
    localparam int C  = 4;

    logic           clk;
    logic           reset;
    logic           start;
    logic [4:0]     num_vectors;
    logic [127:0]   param_in;
    logic           param_load;
    logic [127:0]   param_data;
    logic [31:0]    array_data;
    logic [3:0]     array_valid;
    logic           busy;
    logic           done;

    sys_array_feeder_if #(.ROWS(R), .DATA_WIDTH(DW)) vif ();

    sys_array_feeder #(.DATA_WIDTH(DW), .ROWS(R), .COLS(C), .MAX_VECTORS(16)) dut (
        .clk(clk), .reset(reset), .start(start), .num_vectors(num_vectors),
        .param_in(param_in), .vec_if(vif), .param_load(param_load),
        .param_data(param_data), .array_data(array_data), .array_valid(array_valid),
        .busy(busy), .done(done)
    );

    typedef struct { int lane; int due; logic [7:0] val; } exp_t;
    exp_t exp_q[$];

    int           n_checks = 0;
    int           n_err    = 0;
    int           cyc      = 0;
    logic [7:0]   vecs [0:15][0:3];
    logic [127:0] pw2, pw7;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    // Lane monitor: valid samples must match the oldest queued entry for that lane.
    always @(negedge clk) begin
        for (int r = 0; r < R; r++) begin
            logic [7:0] lane_v;
            int found;
            lane_v = array_data[r*DW +: DW];
            if (array_valid[r]) begin
                found = -1;
                for (int i = 0; i < exp_q.size(); i++)
                    if (found < 0 && exp_q[i].lane == r) found = i;
                if (found < 0) begin
                    check("spurious_valid", 1, 0);
                end else begin
                    check("lane_data", lane_v, exp_q[found].val);
                    check("lane_time", cyc, exp_q[found].due);
                    exp_q.delete(found);
                end
            end else begin
                check("bubble_zero", lane_v, 0);
            end
        end
        if (param_load) check("pl_vs_valid", array_valid, 0);
    end

    // mode 0: valid held, 1: valid toggles, 2: start pulses mid-feed, 3: reset after 2 transfers
    task automatic run_batch(input int n, input int mode);
        int n_eff, acc, p, t_last;
        n_eff       = (n > 16) ? 16 : n;
        start       = 1'b1;
        num_vectors = 5'(n);
        param_in    = pw2;
        @(posedge clk); #1;
        start = 1'b0;
        check("param_load", param_load, 1);
        check("param_data", param_data, pw2);
        check("busy_load", busy, 1);
        check("ready_load", vif.vec_ready, 0);
        @(posedge clk); #1;
        acc = 0;
        p   = 0;
        while (acc < n_eff) begin
            check("param_load_feed", param_load, 0);
            check("ready_feed", vif.vec_ready, 1);
            if (mode == 3 && acc == 2) begin
                reset = 1'b1;
                vif.vec_valid = 1'b0;
                @(posedge clk); #1;
                exp_q.delete();
                check("rst_array_data", array_data, 0);
                check("rst_array_valid", array_valid, 0);
                check("rst_busy", busy, 0);
                check("rst_ready", vif.vec_ready, 0);
                check("rst_param_data", param_data, 0);
                check("rst_param_load", param_load, 0);
                check("rst_done", done, 0);
                reset = 1'b0;
                repeat (4) begin
                    @(posedge clk); #1;
                    check("abort_no_done", done, 0);
                    check("abort_idle", busy, 0);
                end
                return;
            end
            vif.vec_valid = (mode == 1) ? (p % 2 == 0) : 1'b1;
            if (mode == 2 && (p == 1 || p == 2)) begin
                start       = 1'b1;
                num_vectors = 5'd5;
                param_in    = pw7;
            end else begin
                start = 1'b0;
            end
            if (vif.vec_valid) begin
                for (int r = 0; r < R; r++) begin
                    vif.vec_data[r*DW +: DW] = vecs[acc][r];
                    exp_q.push_back('{lane: r, due: cyc + 1 + r, val: vecs[acc][r]});
                end
                acc++;
            end else begin
                vif.vec_data = $urandom;
            end
            p++;
            @(posedge clk); #1;
        end
        vif.vec_valid = 1'b0;
        start         = 1'b0;
        t_last        = cyc;
        while (cyc < t_last + R + C - 1) begin
            check("ready_drain", vif.vec_ready, 0);
            check("done_early", done, 0);
            check("busy_drain", busy, 1);
            @(posedge clk); #1;
        end
        check("done_pulse", done, 1);
        check("busy_end", busy, 0);
        check("param_data_hold", param_data, pw2);
        check("queue_empty", exp_q.size(), 0);
        @(posedge clk); #1;
        check("done_one_cycle", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation timed out");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 16; i++) begin
            pw2[i*8 +: 8] = 8'd2;
            pw7[i*8 +: 8] = 8'd7;
        end
        for (int r = 0; r < R; r++) begin
            vecs[0][r] = 8'(r + 1);
            vecs[1][r] = 8'(r + 5);
            vecs[2][r] = 8'(-(r + 1));
            vecs[3][r] = 8'(r + 9);
        end
        reset         = 1'b1;
        start         = 1'b1;
        num_vectors   = 5'd3;
        param_in      = pw7;
        vif.vec_valid = 1'b0;
        vif.vec_data  = '0;
        repeat (3) begin
            @(posedge clk); #1;
            check("reset_outputs", {param_load, array_valid, busy, done, vif.vec_ready}, 0);
            check("reset_data", {param_data, array_data}, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk); #1;
        check("post_reset_idle", busy, 0);
        check("post_reset_pl", param_load, 0);

        run_batch(3, 0);
        run_batch(3, 1);

        start       = 1'b1;
        num_vectors = 5'd0;
        @(posedge clk); #1;
        start = 1'b0;
        check("n0_done", done, 1);
        check("n0_busy", busy, 0);
        check("n0_pl", param_load, 0);
        @(posedge clk); #1;
        check("n0_done_clear", done, 0);
        check("n0_busy2", busy, 0);

        run_batch(3, 2);
        run_batch(4, 3);
        run_batch(3, 0);

        for (int i = 0; i < 16; i++)
            for (int r = 0; r < R; r++)
                vecs[i][r] = 8'($urandom);
        run_batch(20, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule

// File: doc/sys_array_feeder.md
Name: sys_array_feeder

Overview:
- Upstream stage of the systolic array; drives the left edge and parameter inputs of a ROWS x COLS grid of cells.
- Per batch: latches a full weight set, issues a one-cycle parameter-load pulse, then accepts input vectors over a valid/ready handshake.
- Applies diagonal skew so lane r lags lane 0 by r cycles, then drains with zeros until every result has left the grid.

Parameters:
- DATA_WIDTH, 8, signed width of weights and input samples.
- ROWS, 4, number of input lanes (array height).
- COLS, 4, number of weight columns (array width).
- MAX_VECTORS, 16, largest batch length accepted.
- CNT_W, $clog2(MAX_VECTORS+1), width of the vector counters.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  batch request, sampled only in IDLE.
- num_vectors  in  CNT_W  batch length N, sampled with start.
- param_in  in  ROWS*COLS*DATA_WIDTH  weights; cell (r,c) at slice index r*COLS+c; sampled with start.
- vec_valid  in  1  upstream vector valid.
- vec_data  in  ROWS*DATA_WIDTH  one input vector; lane r at slice r.
- vec_ready  out  1  feeder accepts vec_data this cycle.
- param_load  out  1  to all cells, load weights.
- param_data  out  ROWS*COLS*DATA_WIDTH  registered copy of the captured weights.
- array_data  out  ROWS*DATA_WIDTH  skewed lane samples to the cell input_data pins.
- array_valid  out  ROWS  per-lane flag: the lane carries a real sample, not a bubble or drain zero.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse when the batch has fully drained.

Behaviour:
- Reset: state=IDLE; all outputs 0, including param_data, array_data and every skew register; counters 0.
- Reset has priority over every other input and aborts any batch in progress with no done pulse.
- States: IDLE, LOAD, FEED, DRAIN.
- IDLE:
  - start & N!=0 -> capture N and param_in -> LOAD.
  - start & N==0 -> done=1 for 1 cycle; stay in IDLE.
  - N > MAX_VECTORS is clamped to MAX_VECTORS.
- LOAD: exactly 1 cycle, then FEED.
  - param_load=1; param_data=captured weights; array_data=0; array_valid=0.
  - param_data holds its value after LOAD until the next LOAD or reset.
- FEED:
  - vec_ready = 1 while accepted count < N.
  - Transfer occurs when vec_valid & vec_ready; the vector enters skew stage 0 tagged valid.
  - Cycles without a transfer enter a bubble: data 0, valid 0. Samples still advance every cycle.
  - On the N-th transfer: vec_ready drops in the next cycle -> DRAIN.
- DRAIN:
  - Zeros with valid 0 enter stage 0 for exactly ROWS+COLS-1 cycles.
  - At the end: done=1 for 1 cycle, busy=0, state IDLE, all skew registers hold 0.
- Skew and latency:
  - A vector transferred at edge t appears on lane r at array_data[r] during cycle t+1+r.
  - array_valid[r] is aligned with its data.
  - Lane r uses r+1 register stages; all stages shift every cycle in FEED and DRAIN.
  - Skew registers are forced to 0 in IDLE and LOAD.
- Counters: the accepted count never exceeds N. The drain counter spans 0..ROWS+COLS-2.
- start while busy: ignored; captured N and weights are unchanged.
- param_load is never high in the same cycle as any array_valid bit.
- Arithmetic: none. Data passes through bit-exact with sign preserved; no width change.

Test Plan:
- Reset with outputs idle -> all outputs 0, busy=0; start during reset is ignored.
- start, N=3, param_in all 8'sd2, vec_valid held high, vectors {1,2,3,4},{5,6,7,8},{-1,-2,-3,-4} -> param_load=1 in the cycle after start.
  - Lane 0 shows 1,5,-1 in consecutive cycles starting 2 cycles after start.
  - Lane 3 shows 4,8,-4 starting 3 cycles later.
  - done pulses exactly 1+3+7 cycles after LOAD.
- Same batch with vec_valid toggled 1,0,1,0,1 -> zero bubbles with array_valid=0 appear on each lane, shifted r cycles per lane; N transfers are counted exactly.
- start with N=0 -> done pulses the next cycle; param_load never asserts; busy stays 0.
- start pulses during FEED with a different N and different weights -> ignored; the original batch completes unchanged.
- reset asserted mid-FEED after 2 of 4 vectors -> next cycle all outputs 0, state IDLE, no done pulse; a new batch afterwards behaves as in scenario 2.
